stage2_window_gen: RTL and testbench
====================================

# stage2_window_gen

Stage-2 convolution window generator. Takes the raster-ordered stage-1 feature-map stream (20-bit signed pixels, one channel) and buffers K rows. Emits each complete KxK sliding window, stride 1, as one packed vector on the `i_in_fmap` / `i_in_valid` inputs of the stage-2 kernel. The kernel's multi-cycle accumulation cannot accept back-to-back windows, so the block spaces windows at least GAP idle cycles apart and back-pressures upstream meanwhile.

## Interface
- IMG_W, 12, feature-map width in pixels
- IMG_H, 12, feature-map height in pixels
- K, 5, window size (KX = KY = K)
- DBW, 20, pixel width (equals stage-2 conv input width)
- GAP, 54, minimum idle cycles between consecutive `o_win_valid` pulses (downstream kernel latency + 1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_in_valid  in  1  input pixel valid
- i_in_sof  in  1  with an accepted pixel: pixel is (row 0, col 0) of a new frame
- i_in_data  in  DBW  signed pixel
- o_in_ready  out  1  block accepts a pixel this cycle
- o_win_valid  out  1  one-cycle pulse: `o_win` holds a complete window
- o_win  out  K*K*DBW  element (ky,kx) at [(ky*K+kx)*DBW +: DBW]; ky=0 top row, kx=0 leftmost column
- o_win_row  out  clog2(IMG_H-K+1)  output-map row of the window
- o_win_col  out  clog2(IMG_W-K+1)  output-map column of the window
- o_frame_done  out  1  one-cycle pulse together with the last window of a frame

## Operation
- Accept: `i_in_valid & o_in_ready`. Unaccepted data is not consumed; upstream holds it.
- Position counters `row` (0..IMG_H-1) and `col` (0..IMG_W-1) name the accepted pixel.
  - col wraps at IMG_W-1 and increments row.
  - row wraps at IMG_H-1 to 0.
  - Accepted pixel with `i_in_sof=1` is forced to (0,0); counters continue from there.
- Line buffer: K row slots, slot = row mod K, written at `col`. Contents are never cleared; only validity by position matters.
- A window completes when an accepted pixel has row>=K-1 and col>=K-1.
  - Window rows: rows row-K+1..row; columns col-K+1..col. The current pixel is (K-1,K-1).
  - `o_win_row` = row-K+1, `o_win_col` = col-K+1.
- FSM:
  - IDLE: `o_in_ready=1`. On accept completing a window, go to EMIT; otherwise stay.
  - EMIT (1 cycle): `o_win_valid=1`, `o_in_ready=0`. Go to WAIT if GAP>0, else IDLE.
  - WAIT: `o_in_ready=0`, counter runs GAP cycles, then IDLE.
- `o_frame_done=1` in EMIT when the window is at (IMG_H-K, IMG_W-K).
- Pixels that complete no window (first K-1 rows, first K-1 columns of each row) are accepted in consecutive IDLE cycles without throttling.
- Arithmetic: pure data movement, no sign change; bit-exact copies of `i_in_data`.

## Timing
- Reset values:
  - `o_win_valid`, `o_frame_done`, `o_win`, `o_win_row`, `o_win_col` = 0.
  - `o_in_ready` = 0 while reset is asserted, 1 in the first cycle after release.
  - FSM = IDLE; row = col = 0.
- Accept at cycle t completing a window:
  - `o_win_valid` at t+1.
  - `o_in_ready` low at t+1 .. t+1+GAP.
  - Next accept no earlier than t+2+GAP.
- `o_win`, `o_win_row`, `o_win_col` are registered. They hold after EMIT until the next EMIT.
- Reset mid-frame or mid-WAIT: immediate return to reset state; the pending window is dropped. The next frame needs no `i_in_sof`, since counters are already 0.
- `i_in_sof` arriving mid-frame: the partial frame is abandoned, with no `o_frame_done`. Windows from the new frame appear only after K-1 fresh rows.
- Per frame: (IMG_H-K+1)*(IMG_W-K+1) windows, 64 at default.

## Structure
- Shared defines file `stage2_defines_cnn_core.v` holds K (KX/KY), DBW (`ST2_Conv_IBW`), IMG_W/IMG_H for stage 2, and the GAP constant derived from the kernel latency.
- Sub-module `stage2_line_buffer`:
  - K slots of IMG_W x DBW; write port (slot, col, data).
  - Combinational KxK read of columns col-K+1..col with slot rotation to top-first order.
- Top holds the counters, the FSM, and the output registers.

## Test plan
- IMG_W=IMG_H=12, K=5, GAP=3, pixel = row*16+col, continuous valid.
  - First `o_win_valid` one cycle after pixel (4,4) is accepted.
  - `o_win` (0,0)=0x00, (0,4)=0x04, (4,0)=0x40, (4,4)=0x44; row/col = 0/0.
- Same stream: `o_in_ready` low exactly 4 cycles after each completing accept.
  - 64 windows per frame.
  - Last window (7,7) has (4,4)=0xBB and `o_frame_done=1`.
- Two frames back-to-back, second with `i_in_sof` on its first pixel: identical 64-window sequence; counters wrap cleanly.
- Upstream valid gaps (random idle cycles): same window contents and order; no pixel lost or duplicated while `o_in_ready=0`.
- Reset asserted during WAIT after window (2,3): outputs return to 0 and no further pulse. A fresh frame reproduces the first-window check.
- `i_in_sof` injected at pixel (6,5) of a frame: no `o_frame_done` for that frame. The first new window comes after new-frame pixel (4,4) with values from the new frame only.

Source files
------------

// File: rtl/stage2_window_gen_pkg.sv
// -----------------------------------------------------------------------------
// stage2_window_gen_pkg
// Shared stage-2 constants for the convolution window generator: feature-map
// geometry, kernel size, pixel width and the inter-window gap that follows
// from the downstream kernel latency. Also holds the window FSM state type.
// -----------------------------------------------------------------------------
package stage2_window_gen_pkg;

    localparam int ST2_IMG_W      = 12;   // stage-2 feature-map width
    localparam int ST2_IMG_H      = 12;   // stage-2 feature-map height
    localparam int ST2_K          = 5;    // KX = KY
    localparam int ST2_CONV_IBW   = 20;   // stage-2 conv input width
    localparam int ST2_KERNEL_LAT = 53;   // kernel accumulation latency
    // Idle cycles between windows: kernel latency plus one turnaround cycle.
    localparam int ST2_GAP        = ST2_KERNEL_LAT + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_WAIT = 2'd2
    } win_state_e;

endpackage

// File: rtl/stage2_window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// stage2_line_buffer
// K row slots of IMG_W pixels. One write port (slot, col, data) and a
// combinational KxK read of columns col-K+1..col, rotated so the oldest row
// comes out on top. The pixel being written is bypassed straight into the
// bottom-right element so the window is complete in the accept cycle.
// Ports:
//   clk      : clock
//   i_we     : write enable (pixel accepted)
//   i_slot   : slot of the current row (row mod K)
//   i_col    : column of the current pixel
//   i_data   : current pixel
//   o_win    : KxK window, element (ky,kx) at [(ky*K+kx)*DBW +: DBW]
// -----------------------------------------------------------------------------
module stage2_line_buffer #(
    parameter int IMG_W = 12,
    parameter int K     = 5,
    parameter int DBW   = 20,
    parameter int SW    = 3,
    parameter int CW    = 4
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [SW-1:0]      i_slot,
    input  logic [CW-1:0]      i_col,
    input  logic [DBW-1:0]     i_data,
    output logic [K*K*DBW-1:0] o_win
);

    logic [DBW-1:0] r_mem [K][IMG_W];

    // Row storage write; contents are never cleared, only position gives validity
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_slot][i_col] <= i_data;
        end
    end

    // Window gather: slot after the current one holds the oldest (top) row
    always_comb begin
        int v_slot;
        int v_col;
        v_slot = 0;
        v_col  = 0;
        o_win  = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                v_slot = (int'(i_slot) + 1 + ky) % K;
                v_col  = int'(i_col) - (K - 1) + kx;
                if (v_col < 0) begin
                    v_col = 0;
                end else begin
                    v_col = v_col;
                end
                if ((ky == K - 1) && (kx == K - 1)) begin
                    o_win[(ky*K+kx)*DBW +: DBW] = i_data;
                end else begin
                    o_win[(ky*K+kx)*DBW +: DBW] = r_mem[SW'(v_slot)][CW'(v_col)];
                end
            end
        end
    end

endmodule

// File: rtl/stage2_window_gen.sv
// -----------------------------------------------------------------------------
// stage2_window_gen
// Buffers K rows of the raster-ordered stage-1 feature map and emits every
// complete KxK stride-1 window as one packed vector, spacing windows at least
// GAP idle cycles apart and back-pressuring upstream meanwhile.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_in_valid    : input pixel valid
//   i_in_sof      : accepted pixel is (0,0) of a new frame
//   i_in_data     : signed pixel
//   o_in_ready    : block accepts a pixel this cycle
//   o_win_valid   : one-cycle pulse, o_win holds a window
//   o_win         : packed window, (ky,kx) at [(ky*K+kx)*DBW +: DBW]
//   o_win_row/col : output-map position of the window
//   o_frame_done  : pulse with the last window of a frame
// -----------------------------------------------------------------------------
module stage2_window_gen
    import stage2_window_gen_pkg::*;
#(
    parameter int IMG_W = ST2_IMG_W,
    parameter int IMG_H = ST2_IMG_H,
    parameter int K     = ST2_K,
    parameter int DBW   = ST2_CONV_IBW,
    parameter int GAP   = ST2_GAP,
    localparam int OWR  = $clog2(IMG_H - K + 1),
    localparam int OWC  = $clog2(IMG_W - K + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_in_valid,
    input  logic               i_in_sof,
    input  logic [DBW-1:0]     i_in_data,
    output logic               o_in_ready,
    output logic               o_win_valid,
    output logic [K*K*DBW-1:0] o_win,
    output logic [OWR-1:0]     o_win_row,
    output logic [OWC-1:0]     o_win_col,
    output logic               o_frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int SW = (K > 1) ? $clog2(K) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    win_state_e         r_state, w_next_state;
    logic [GW-1:0]      r_gap_cnt, w_next_gap_cnt;
    logic [RW-1:0]      r_row, w_pos_row, w_next_row;
    logic [CW-1:0]      r_col, w_pos_col, w_next_col;
    logic [SW-1:0]      r_slot, w_pos_slot, w_next_slot;
    logic               r_in_ready;
    logic               r_win_valid;
    logic               r_frame_done;
    logic [K*K*DBW-1:0] r_win;
    logic [OWR-1:0]     r_win_row;
    logic [OWC-1:0]     r_win_col;
    logic               w_acc;
    logic               w_win_done;
    logic               w_frame_last;
    logic [K*K*DBW-1:0] w_lb_win;

    assign o_in_ready   = r_in_ready;
    assign o_win_valid  = r_win_valid;
    assign o_frame_done = r_frame_done;
    assign o_win        = r_win;
    assign o_win_row    = r_win_row;
    assign o_win_col    = r_win_col;

    // Position of the pixel offered now (sof forces (0,0)) and the one after it
    always_comb begin
        w_acc = i_in_valid & r_in_ready;
        if (i_in_sof) begin
            w_pos_row  = '0;
            w_pos_col  = '0;
            w_pos_slot = '0;
        end else begin
            w_pos_row  = r_row;
            w_pos_col  = r_col;
            w_pos_slot = r_slot;
        end
        if (w_pos_col == CW'(IMG_W - 1)) begin
            w_next_col = '0;
            if (w_pos_row == RW'(IMG_H - 1)) begin
                w_next_row  = '0;
                w_next_slot = '0;
            end else begin
                w_next_row  = w_pos_row + RW'(1);
                w_next_slot = (w_pos_slot == SW'(K - 1)) ? SW'(0) : w_pos_slot + SW'(1);
            end
        end else begin
            w_next_col  = w_pos_col + CW'(1);
            w_next_row  = w_pos_row;
            w_next_slot = w_pos_slot;
        end
        w_win_done   = w_acc && (w_pos_row >= RW'(K - 1)) && (w_pos_col >= CW'(K - 1));
        w_frame_last = (w_pos_row == RW'(IMG_H - 1)) && (w_pos_col == CW'(IMG_W - 1));
    end

    // Next-state logic: IDLE -> EMIT on a completing accept, then GAP WAIT cycles
    always_comb begin
        w_next_state   = r_state;
        w_next_gap_cnt = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_win_done) begin
                    w_next_state = S_EMIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EMIT: begin
                w_next_gap_cnt = '0;
                if (GAP > 0) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_gap_cnt == GW'(GAP - 1)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_gap_cnt = r_gap_cnt + GW'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state, gap counter and ready (ready follows the state being entered)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gap_cnt  <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_gap_cnt  <= w_next_gap_cnt;
            r_in_ready <= (w_next_state == S_IDLE);
        end
    end

    // Raster position counters, advanced on every accepted pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row  <= '0;
            r_col  <= '0;
            r_slot <= '0;
        end else if (w_acc) begin
            r_row  <= w_next_row;
            r_col  <= w_next_col;
            r_slot <= w_next_slot;
        end else begin
            r_row  <= r_row;
            r_col  <= r_col;
            r_slot <= r_slot;
        end
    end

    // Window output registers: pulse flags every cycle, payload held until next window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win        <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
        end else begin
            r_win_valid  <= w_win_done;
            r_frame_done <= w_win_done && w_frame_last;
            if (w_win_done) begin
                r_win     <= w_lb_win;
                r_win_row <= OWR'(w_pos_row - RW'(K - 1));
                r_win_col <= OWC'(w_pos_col - CW'(K - 1));
            end else begin
                r_win     <= r_win;
                r_win_row <= r_win_row;
                r_win_col <= r_win_col;
            end
        end
    end

    stage2_line_buffer #(
        .IMG_W (IMG_W),
        .K     (K),
        .DBW   (DBW),
        .SW    (SW),
        .CW    (CW)
    ) u_line_buffer (
        .clk    (clk),
        .i_we   (w_acc),
        .i_slot (w_pos_slot),
        .i_col  (w_pos_col),
        .i_data (i_in_data),
        .o_win  (w_lb_win)
    );

endmodule

// File: tb/tb_stage2_window_gen.sv
// -----------------------------------------------------------------------------
// tb_stage2_window_gen
// Directed bench for stage2_window_gen with GAP=3. Pixels carry
// base + row*16 + col, so every expected window element is computed here.
// -----------------------------------------------------------------------------
module tb_stage2_window_gen;

    localparam int IMG_W = 12;
    localparam int IMG_H = 12;
    localparam int K     = 5;
    localparam int DBW   = 20;
    localparam int GAP   = 3;
    localparam int OWN   = IMG_W - K + 1;
    localparam int NWIN  = (IMG_H - K + 1) * OWN;
    localparam int WW    = K * K * DBW;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_in_valid;
    logic           i_in_sof;
    logic [DBW-1:0] i_in_data;
    logic           o_in_ready;
    logic           o_win_valid;
    logic [WW-1:0]  o_win;
    logic [2:0]     o_win_row;
    logic [2:0]     o_win_col;
    logic           o_frame_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            q_row[$];
    int            q_col[$];
    int            q_cyc[$];
    logic [WW-1:0] q_win[$];
    logic          q_fd[$];
    bit            cnt_en = 1'b0;
    int            low_cnt = 0;
    int            acc_cyc[IMG_W*IMG_H];

    stage2_window_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .DBW   (DBW),
        .GAP   (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .i_in_sof     (i_in_sof),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_win_valid  (o_win_valid),
        .o_win        (o_win),
        .o_win_row    (o_win_row),
        .o_win_col    (o_win_col),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Window collector and ready-low counter, sampled on the falling edge
    always @(negedge clk) begin
        if (o_win_valid) begin
            q_row.push_back(int'(o_win_row));
            q_col.push_back(int'(o_win_col));
            q_cyc.push_back(cyc);
            q_win.push_back(o_win);
            q_fd.push_back(o_frame_done);
        end
        if (cnt_en && !o_in_ready) low_cnt = low_cnt + 1;
    end

    function automatic logic [WW-1:0] exp_win(input int base, input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                w[(ky*K+kx)*DBW +: DBW] = DBW'(base + (r + ky) * 16 + (c + kx));
        return w;
    endfunction

    task automatic clear_q();
        q_row.delete(); q_col.delete(); q_cyc.delete(); q_win.delete(); q_fd.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_in_valid = 1'b0;
            i_in_sof   = 1'b0;
        end
    endtask

    // Offer one pixel and hold it until accepted; ac = cycle of the accept
    task automatic send_pixel(input logic [DBW-1:0] d, input logic sof, output int ac);
        int   budget;
        bit   done;
        logic rdy;
        budget = 0;
        done   = 1'b0;
        ac     = 0;
        while (!done) begin
            @(negedge clk);
            i_in_valid = 1'b1;
            i_in_data  = d;
            i_in_sof   = sof;
            rdy        = o_in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ac   = cyc - 1;
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 200) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL accept_timeout: o_in_ready low for %0d cycles, required high within 200", budget);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_range(input int base, input bit sof_first, input int max_gap,
                              input int first, input int last_excl);
        int ac;
        for (int idx = first; idx < last_excl; idx++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_pixel(DBW'(base + (idx / IMG_W) * 16 + (idx % IMG_W)),
                       sof_first && (idx == first), ac);
            acc_cyc[idx] = ac;
        end
    endtask

    task automatic check_frame(input int base, input int qoff, input int n, input string tag);
        int r, c;
        n_assert++;
        if (q_win.size() < qoff + n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d windows, required at least %0d", tag, q_win.size(), qoff + n);
        end else begin
            for (int k = 0; k < n; k++) begin
                r = k / OWN;
                c = k % OWN;
                n_assert++;
                if (q_row[qoff+k] !== r || q_col[qoff+k] !== c ||
                    q_win[qoff+k] !== exp_win(base, r, c) || q_fd[qoff+k] !== (k == NWIN - 1)) begin
                    n_fail++;
                    $display("FAIL %s_win%0d: got row %0d col %0d fd %0b win %h, required row %0d col %0d fd %0b win %h",
                             tag, k, q_row[qoff+k], q_col[qoff+k], q_fd[qoff+k], q_win[qoff+k],
                             r, c, (k == NWIN - 1), exp_win(base, r, c));
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_assert++;
        if (o_win_valid !== 1'b0 || o_frame_done !== 1'b0 || o_win !== '0 ||
            o_win_row !== 3'd0 || o_win_col !== 3'd0 || o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got valid %0b fd %0b row %0d col %0d ready %0b win %h, required all 0",
                     tag, o_win_valid, o_frame_done, o_win_row, o_win_col, o_in_ready, o_win);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_in_sof   = 1'b0;
        i_in_data  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        n_assert++;
        if (o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b, required 1", o_in_ready);
        end
    endtask

    task automatic test_first_frame();
        logic [WW-1:0] w;
        int idx;
        clear_q();
        low_cnt = 0;
        cnt_en  = 1'b1;
        send_range(0, 1'b0, 0, 0, IMG_W * IMG_H);
        idle(10);
        cnt_en = 1'b0;
        n_assert++;
        if (q_win.size() !== NWIN) begin
            n_fail++;
            $display("FAIL frame_window_count: got %0d, required %0d", q_win.size(), NWIN);
        end
        if (q_win.size() > 0) begin
            w = q_win[0];
            n_assert++;
            if (w[0 +: DBW] !== 20'h00000 || w[4*DBW +: DBW] !== 20'h00004 ||
                w[20*DBW +: DBW] !== 20'h00040 || w[24*DBW +: DBW] !== 20'h00044 ||
                q_row[0] !== 0 || q_col[0] !== 0) begin
                n_fail++;
                $display("FAIL first_window: got corners %h %h %h %h row %0d col %0d, required 00000 00004 00040 00044 row 0 col 0",
                         w[0 +: DBW], w[4*DBW +: DBW], w[20*DBW +: DBW], w[24*DBW +: DBW], q_row[0], q_col[0]);
            end
            n_assert++;
            if (q_cyc[0] !== acc_cyc[4*IMG_W+4] + 1) begin
                n_fail++;
                $display("FAIL first_window_latency: got cycle %0d, required %0d", q_cyc[0], acc_cyc[4*IMG_W+4] + 1);
            end
            w = q_win[q_win.size()-1];
            n_assert++;
            if (w[24*DBW +: DBW] !== 20'h000BB || q_fd[q_fd.size()-1] !== 1'b1) begin
                n_fail++;
                $display("FAIL last_window: got (4,4) %h fd %0b, required 000bb fd 1", w[24*DBW +: DBW], q_fd[q_fd.size()-1]);
            end
        end
        n_assert++;
        if (low_cnt !== NWIN * (GAP + 1)) begin
            n_fail++;
            $display("FAIL ready_low_cycles: got %0d, required %0d", low_cnt, NWIN * (GAP + 1));
        end
        // A completing accept must delay the next accept by exactly GAP+2 cycles
        for (int r = K - 1; r < IMG_H; r++) begin
            for (int c = K - 1; c < IMG_W; c++) begin
                idx = r * IMG_W + c;
                if (idx + 1 < IMG_W * IMG_H) begin
                    n_assert++;
                    if (acc_cyc[idx+1] !== acc_cyc[idx] + GAP + 2) begin
                        n_fail++;
                        $display("FAIL accept_spacing_r%0d_c%0d: got %0d cycles, required %0d",
                                 r, c, acc_cyc[idx+1] - acc_cyc[idx], GAP + 2);
                    end
                end
            end
        end
        check_frame(0, 0, NWIN, "frame1");
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_range(0, 1'b0, 0, 0, IMG_W * IMG_H);
        send_range(0, 1'b1, 0, 0, IMG_W * IMG_H);
        idle(10);
        n_assert++;
        if (q_win.size() !== 2 * NWIN) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, required %0d", q_win.size(), 2 * NWIN);
        end
        check_frame(0, 0, NWIN, "b2b_a");
        check_frame(0, NWIN, NWIN, "b2b_b");
    endtask

    task automatic test_valid_gaps();
        clear_q();
        send_range(20'h300, 1'b0, 3, 0, IMG_W * IMG_H);
        idle(10);
        n_assert++;
        if (q_win.size() !== NWIN) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d, required %0d", q_win.size(), NWIN);
        end
        check_frame(20'h300, 0, NWIN, "gaps");
    endtask

    task automatic test_reset_mid_wait();
        clear_q();
        send_range(0, 1'b0, 0, 0, 6 * IMG_W + 8);
        idle(3);
        n_assert++;
        if (q_row.size() == 0 || q_row[q_row.size()-1] !== 2 || q_col[q_col.size()-1] !== 3 || o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_window: got %0d windows, ready %0b, required last window (2,3) and ready 0",
                     q_row.size(), o_in_ready);
        end
        reset = 1'b1;
        #2;
        check_idle_outputs("reset_mid_wait");
        idle(2);
        reset = 1'b0;
        clear_q();
        idle(20);
        n_assert++;
        if (q_win.size() !== 0) begin
            n_fail++;
            $display("FAIL no_pulse_after_reset: got %0d windows, required 0", q_win.size());
        end
        clear_q();
        send_range(0, 1'b0, 0, 0, IMG_W * IMG_H);
        idle(10);
        n_assert++;
        if (q_cyc.size() == 0 || q_cyc[0] !== acc_cyc[4*IMG_W+4] + 1) begin
            n_fail++;
            $display("FAIL post_reset_first_latency: got %0d windows, required first one cycle after pixel (4,4)", q_cyc.size());
        end
        check_frame(0, 0, NWIN, "post_reset");
    endtask

    task automatic test_sof_midframe();
        int n_old;
        n_old = 2 * OWN + 1;
        clear_q();
        send_range(0, 1'b0, 0, 0, 6 * IMG_W + 5);
        send_range(20'h800, 1'b1, 0, 0, IMG_W * IMG_H);
        idle(10);
        n_assert++;
        if (q_win.size() !== n_old + NWIN) begin
            n_fail++;
            $display("FAIL sof_mid_count: got %0d, required %0d", q_win.size(), n_old + NWIN);
        end
        check_frame(0, 0, n_old, "sof_old");
        check_frame(20'h800, n_old, NWIN, "sof_new");
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_valid_gaps();
        test_reset_mid_wait();
        test_sof_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
